ads1115_level_filter: RTL

Downstream consumer of the ADS1115 I2C reader's 16-bit conversion result. It accepts one sample per `sample_valid` strobe and forms a power-of-two moving average. It classifies the average into FAULT / NORMAL / HIGH zones with hysteresis, and drives the status LEDs. It replaces raw per-sample threshold compares, which flicker on noisy readings.

---
 rtl/ads1115_level_filter_if.sv | 21 ++
 rtl/ads1115_level_filter.sv | 105 ++++++++++
 2 files changed

// File: rtl/ads1115_level_filter_if.sv
// ads1115_level_filter_if: sample-in / level-status bundle for ads1115_level_filter.
// Signals:
//   sample_in[15:0]  raw ADS1115 conversion (two's complement), qualified by sample_valid
//   sample_valid     one-cycle strobe, may be high every cycle
//   avg_out[15:0]    current window average
//   avg_valid        pulse when avg_out takes a full-window average
//   zone[1:0]        00 FAULT, 01 NORMAL, 10 HIGH
//   zone_change      pulse when zone changes
//   led_n[2:0]       active-low one-hot: [0] FAULT, [1] NORMAL, [2] HIGH
// master drives samples; slave is the filter.
interface ads1115_level_filter_if;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [15:0] avg_out;
  logic        avg_valid;
  logic [1:0]  zone;
  logic        zone_change;
  logic [2:0]  led_n;
  modport master (output sample_in, sample_valid, input avg_out, avg_valid, zone, zone_change, led_n);
  modport slave  (input sample_in, sample_valid, output avg_out, avg_valid, zone, zone_change, led_n);
endinterface

// File: rtl/ads1115_level_filter.sv
// ads1115_level_filter: power-of-two moving average of ADS1115 samples with FAULT/NORMAL/HIGH zoning and status LEDs.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ads1115_level_filter_if.slave (samples in; average, zone, LEDs out)
// Macro ADS_LEVEL_HYST_EN: when defined, zone transitions use the HYST margin;
// when undefined, zone is a pure function of the latest average.
module ads1115_level_filter #(
  parameter int          AVG_LOG2 = 3,
  parameter logic [15:0] LOW_TH   = 16'h0FA0,
  parameter logic [15:0] HIGH_TH  = 16'h59D8,
  parameter logic [15:0] OVER_TH  = 16'h7D00,
  parameter logic [15:0] HYST     = 16'h0100
) (
  input logic                   clk,
  input logic                   rst_n,
  ads1115_level_filter_if.slave bus
);
  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 16 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(N);
`ifdef ADS_LEVEL_HYST_EN
  localparam logic [16:0] H = {1'b0, HYST};
`else
  // Margin forced to zero; HYST stays referenced so both builds share one parameter list.
  localparam logic [16:0] H = {1'b0, HYST & 16'h0000};
`endif
  // 17-bit thresholds so threshold +/- margin cannot wrap.
  localparam logic [16:0] LO = {1'b0, LOW_TH};
  localparam logic [16:0] HI = {1'b0, HIGH_TH};
  localparam logic [16:0] OV = {1'b0, OVER_TH};
  typedef enum logic [1:0] {FAULT = 2'b00, NORMAL = 2'b01, HIGH = 2'b10} zone_e;
  logic [15:0]         buf_q [N];
  logic [AVG_LOG2-1:0] wr_ptr_q;
  logic [AVG_LOG2:0]   fill_q, fill_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic                full_q;
  logic [15:0]         avg_q;
  logic                avg_valid_q;
  zone_e               zone_q, zone_d;
  logic                zone_change_q;
  logic [2:0]          led_q;
  logic [15:0]         smp, evict;
  logic [16:0]         a;
  logic                flt;
  always_comb begin
    smp    = bus.sample_in[15] ? 16'h0000 : bus.sample_in;
    // Until the window is full the slot being overwritten holds stale data, not a window member.
    evict  = (fill_q == FULL) ? buf_q[wr_ptr_q] : 16'h0000;
    fill_d = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    sum_d  = sum_q + SW'(smp) - SW'(evict);
  end
  // Sample buffer deliberately has no reset; the fill count masks its contents.
  always_ff @(posedge clk)
    if (bus.sample_valid) buf_q[wr_ptr_q] <= smp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      full_q      <= 1'b0;
      avg_q       <= 16'h0000;
      avg_valid_q <= 1'b0;
    end else begin
      if (bus.sample_valid) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        fill_q   <= fill_d;
        sum_q    <= sum_d;
      end
      full_q      <= bus.sample_valid && fill_d == FULL;
      avg_valid_q <= full_q;
      if (full_q) avg_q <= sum_q[SW-1:AVG_LOG2];
    end
  always_comb begin
    a      = {1'b0, avg_q};
    flt    = a < LO || a > OV;
    zone_d = zone_q;
    if (avg_valid_q) begin
`ifdef ADS_LEVEL_HYST_EN
      case (zone_q)
        NORMAL:  zone_d = flt ? FAULT : (a > HI + H) ? HIGH : NORMAL;
        HIGH:    zone_d = flt ? FAULT : (a < HI - H) ? NORMAL : HIGH;
        default: zone_d = (a >= LO + H && a <= HI) ? NORMAL : (a > HI && a <= OV - H) ? HIGH : FAULT;
      endcase
`else
      zone_d = flt ? FAULT : (a > HI + H) ? HIGH : NORMAL;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      zone_q        <= FAULT;
      zone_change_q <= 1'b0;
      led_q         <= 3'b110;
    end else begin
      zone_q        <= zone_d;
      zone_change_q <= zone_d != zone_q;
      led_q         <= ~(3'b001 << zone_d);
    end
  assign bus.avg_out     = avg_q;
  assign bus.avg_valid   = avg_valid_q;
  assign bus.zone        = zone_q;
  assign bus.zone_change = zone_change_q;
  assign bus.led_n       = led_q;
endmodule
